twiddle_rom_arbiter: RTL and testbench

Shares one quarter-wave cos/sin ROM pair between two twiddle consumers in the FFT clock domain. Each requester presents a full-circle twiddle index. The block grants requesters round-robin and drives the quarter-wave ROM addresses. It then applies quadrant swap and negation to the raw ROM words and returns a tagged, registered cos/sin pair a fixed number of cycles later. It sits between the post-FFT correction stages and the `coshex`/`sinhex` ROM instances, replacing per-stage ROM copies.

---
 rtl/twiddle_rom_arbiter.sv | 161 ++++++++++++++++
 tb/tb_twiddle_rom_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_rom_arbiter.sv
// Round-robin share of one quarter-wave cos/sin ROM pair between two
// twiddle requesters, with quadrant mapping and a tagged registered reply.
//
// Ports:
//   clk_fft, reset          sole clock, synchronous active-high reset
//   enable                  gates new grants only; in-flight work drains
//   req0_*/req1_*           valid/index in, combinational ready (grant) out
//   rom_add, rom_add_sin    registered quarter-wave address to cos/sin ROMs
//   rom_cr, rom_ci          raw ROM words, valid rom_latency after address
//   rsp_valid/id/cos/sin    one-cycle response strobe, data held otherwise
//   busy                    any request still in flight
module twiddle_rom_arbiter #(
    parameter int log2_transform_length = 15,
    parameter int twiddle_width         = 16,
    parameter int rom_latency           = 2
) (
    input  logic                             clk_fft,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             req0_valid,
    input  logic [log2_transform_length-1:0] req0_index,
    output logic                             req0_ready,
    input  logic                             req1_valid,
    input  logic [log2_transform_length-1:0] req1_index,
    output logic                             req1_ready,
    output logic [log2_transform_length-3:0] rom_add,
    output logic [log2_transform_length-3:0] rom_add_sin,
    input  logic [twiddle_width-1:0]         rom_cr,
    input  logic [twiddle_width-1:0]         rom_ci,
    output logic                             rsp_valid,
    output logic                             rsp_id,
    output logic [twiddle_width-1:0]         rsp_cos,
    output logic [twiddle_width-1:0]         rsp_sin,
    output logic                             busy
);

    localparam int L  = log2_transform_length;
    localparam int AW = log2_transform_length - 2;
    localparam int W  = twiddle_width;
    // Address stage plus rom_latency delay stages, so the tag lines up
    // with ROM data in the cycle the response register samples it.
    localparam int D  = rom_latency + 1;

    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

    logic           last;
    logic           grant0;
    logic           grant1;
    logic           accept;
    logic           acc_id;
    logic [L-1:0]   acc_idx;

    logic [D-1:0]   pipe_valid;
    logic [D-1:0]   pipe_id;
    logic [1:0]     pipe_q [D];

    logic [W-1:0]   map_cos;
    logic [W-1:0]   map_sin;

    function automatic logic [W-1:0] neg_sat(input logic [W-1:0] x);
        if (x == MIN_VAL) begin
            return MAX_VAL;
        end
        return (~x) + 1'b1;
    endfunction

    // Grant is purely a function of valids, enable and the last winner.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && enable) begin
            if (req0_valid && req1_valid) begin
                grant0 = last;
                grant1 = !last;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;
    assign acc_id     = grant1;
    assign acc_idx    = grant1 ? req1_index : req0_index;

    always_ff @(posedge clk_fft) begin
        if (reset) begin
            last    <= 1'b1;
            rom_add <= '0;
        end else if (accept) begin
            last    <= acc_id;
            rom_add <= acc_idx[AW-1:0];
        end
    end

    // Both ROMs always see the same quarter-wave address.
    assign rom_add_sin = rom_add;

    always_ff @(posedge clk_fft) begin
        if (reset) begin
            pipe_valid <= '0;
            pipe_id    <= '0;
            for (int i = 0; i < D; i++) begin
                pipe_q[i] <= 2'd0;
            end
        end else begin
            pipe_valid <= {pipe_valid[D-2:0], accept};
            pipe_id    <= {pipe_id[D-2:0], acc_id};
            pipe_q[0]  <= acc_idx[L-1:L-2];
            for (int i = 1; i < D; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Fold the quarter-wave words back onto the full circle.
    always_comb begin
        map_cos = rom_cr;
        map_sin = rom_ci;
        unique case (pipe_q[D-1])
            2'd0: begin
                map_cos = rom_cr;
                map_sin = rom_ci;
            end
            2'd1: begin
                map_cos = neg_sat(rom_ci);
                map_sin = rom_cr;
            end
            2'd2: begin
                map_cos = neg_sat(rom_cr);
                map_sin = neg_sat(rom_ci);
            end
            2'd3: begin
                map_cos = rom_ci;
                map_sin = neg_sat(rom_cr);
            end
        endcase
    end

    always_ff @(posedge clk_fft) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_cos   <= '0;
            rsp_sin   <= '0;
        end else begin
            rsp_valid <= pipe_valid[D-1];
            if (pipe_valid[D-1]) begin
                rsp_id  <= pipe_id[D-1];
                rsp_cos <= map_cos;
                rsp_sin <= map_sin;
            end
        end
    end

    assign busy = (|pipe_valid) | rsp_valid;

endmodule

// File: tb/tb_twiddle_rom_arbiter.sv
// Directed bench for twiddle_rom_arbiter with a 2-cycle ROM model.
// ROM contents: C[r] = 0x1000 + r, S[r] = 2*r (optionally C forced to 0x8000).
module tb_twiddle_rom_arbiter;

    logic        clk_fft;
    logic        reset;
    logic        enable;
    logic        req0_valid;
    logic [14:0] req0_index;
    logic        req0_ready;
    logic        req1_valid;
    logic [14:0] req1_index;
    logic        req1_ready;
    logic [12:0] rom_add;
    logic [12:0] rom_add_sin;
    logic [15:0] rom_cr;
    logic [15:0] rom_ci;
    logic        rsp_valid;
    logic        rsp_id;
    logic [15:0] rsp_cos;
    logic [15:0] rsp_sin;
    logic        busy;

    int checks;
    int failures;
    int cyc;
    logic force_min;

    typedef struct {
        logic        id;
        logic [14:0] k;
        int          edge_no;
    } acc_t;

    typedef struct {
        logic        id;
        logic [15:0] c;
        logic [15:0] s;
        int          cyc_no;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];

    twiddle_rom_arbiter dut (
        .clk_fft     (clk_fft),
        .reset       (reset),
        .enable      (enable),
        .req0_valid  (req0_valid),
        .req0_index  (req0_index),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_index  (req1_index),
        .req1_ready  (req1_ready),
        .rom_add     (rom_add),
        .rom_add_sin (rom_add_sin),
        .rom_cr      (rom_cr),
        .rom_ci      (rom_ci),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_cos     (rsp_cos),
        .rsp_sin     (rsp_sin),
        .busy        (busy)
    );

    initial begin
        clk_fft = 1'b0;
        forever #5 clk_fft = ~clk_fft;
    end

    always @(posedge clk_fft) cyc++;

    // Two-cycle synchronous ROM pair.
    logic [12:0] a_c;
    logic [12:0] a_s;
    always @(posedge clk_fft) begin
        a_c    <= rom_add;
        a_s    <= rom_add_sin;
        rom_cr <= force_min ? 16'h8000 : 16'(32'h1000 + int'(a_c));
        rom_ci <= 16'(2 * int'(a_s));
    end

    // Accept edge = next posedge; response cycle = posedge just passed.
    always @(negedge clk_fft) begin
        acc_t a;
        rsp_t r;
        if (req0_valid && req0_ready) begin
            a.id = 1'b0; a.k = req0_index; a.edge_no = cyc + 1;
            acc_q.push_back(a);
        end
        if (req1_valid && req1_ready) begin
            a.id = 1'b1; a.k = req1_index; a.edge_no = cyc + 1;
            acc_q.push_back(a);
        end
        if (rsp_valid) begin
            r.id = rsp_id; r.c = rsp_cos; r.s = rsp_sin; r.cyc_no = cyc;
            rsp_q.push_back(r);
        end
    end

    task automatic do_reset();
        @(posedge clk_fft); #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clk_fft);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk_fft); #1;
        reset = 1'b1; enable = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_index = 15'd7; req1_index = 15'd9;
        @(negedge clk_fft);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
        end
        checks++;
        if (rom_add !== 13'd0 || rom_add_sin !== 13'd0) begin
            failures++;
            $display("FAIL reset_rom_add got %0d/%0d want 0", rom_add, rom_add_sin);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got v=%b id=%b busy=%b want 0", rsp_valid, rsp_id, busy);
        end
        checks++;
        if (rsp_cos !== 16'h0 || rsp_sin !== 16'h0) begin
            failures++;
            $display("FAIL reset_data got %h/%h want 0000/0000", rsp_cos, rsp_sin);
        end
        @(posedge clk_fft); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        int first;
        acc_q.delete(); rsp_q.delete();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_fft); #1;
            req0_valid = 1'b1;
            req0_index = 15'(i);
            @(negedge clk_fft);
            checks++;
            if (req0_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_ready k=%0d got %b want 1", i, req0_ready);
            end
        end
        @(posedge clk_fft); #1 req0_valid = 1'b0;
        repeat (8) @(posedge clk_fft);
        @(negedge clk_fft);
        checks++;
        if (rsp_q.size() != 16 || acc_q.size() != 16) begin
            failures++;
            $display("FAIL stream_count got rsp=%0d acc=%0d want 16", rsp_q.size(), acc_q.size());
        end else begin
            first = acc_q[0].edge_no;
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rsp_q[i].cyc_no != first + 3 + i || rsp_q[i].id !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_time i=%0d got cyc=%0d id=%b want cyc=%0d id=0",
                             i, rsp_q[i].cyc_no, rsp_q[i].id, first + 3 + i);
                end
                checks++;
                if (rsp_q[i].c !== 16'(32'h1000 + i) || rsp_q[i].s !== 16'(2 * i)) begin
                    failures++;
                    $display("FAIL stream_data k=%0d got %h/%h want %h/%h", i,
                             rsp_q[i].c, rsp_q[i].s, 16'(32'h1000 + i), 16'(2 * i));
                end
            end
        end
    endtask

    task automatic test_alternate();
        int n0;
        do_reset();
        acc_q.delete(); rsp_q.delete();
        @(posedge clk_fft); #1;
        req0_valid = 1'b1; req0_index = 15'd100;
        req1_valid = 1'b1; req1_index = 15'd200;
        repeat (20) @(posedge clk_fft);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk_fft);
        @(negedge clk_fft);
        checks++;
        if (acc_q.size() != 20 || rsp_q.size() != 20) begin
            failures++;
            $display("FAIL alt_count got acc=%0d rsp=%0d want 20", acc_q.size(), rsp_q.size());
        end else begin
            n0 = 0;
            for (int i = 0; i < 20; i++) begin
                if (acc_q[i].id == 1'b0) n0++;
                checks++;
                if (acc_q[i].id !== 1'(i % 2) || rsp_q[i].id !== 1'(i % 2)) begin
                    failures++;
                    $display("FAIL alt_order i=%0d got grant=%b rsp=%b want %0d",
                             i, acc_q[i].id, rsp_q[i].id, i % 2);
                end
                checks++;
                if ((i % 2 == 0 && (rsp_q[i].c !== 16'h1064 || rsp_q[i].s !== 16'h00C8)) ||
                    (i % 2 == 1 && (rsp_q[i].c !== 16'h10C8 || rsp_q[i].s !== 16'h0190))) begin
                    failures++;
                    $display("FAIL alt_data i=%0d got %h/%h", i, rsp_q[i].c, rsp_q[i].s);
                end
            end
            checks++;
            if (n0 != 10) begin
                failures++;
                $display("FAIL alt_share got req0=%0d want 10", n0);
            end
        end
    endtask

    task automatic test_quadrant();
        logic [14:0] ks [4];
        logic [15:0] ec [4];
        logic [15:0] es [4];
        ks = '{15'd5, 15'd8197, 15'd16389, 15'd24581};
        ec = '{16'h1005, 16'hFFF6, 16'hEFFB, 16'h000A};
        es = '{16'h000A, 16'h1005, 16'hFFF6, 16'hEFFB};
        acc_q.delete(); rsp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_fft); #1;
            req1_valid = 1'b1; req1_index = ks[i];
            @(posedge clk_fft); #1;
            req1_valid = 1'b0;
            checks++;
            if (rom_add !== 13'd5 || rom_add_sin !== 13'd5) begin
                failures++;
                $display("FAIL quad_addr k=%0d got %0d/%0d want 5", ks[i], rom_add, rom_add_sin);
            end
        end
        repeat (6) @(posedge clk_fft);
        @(negedge clk_fft);
        checks++;
        if (rsp_q.size() != 4) begin
            failures++;
            $display("FAIL quad_count got %0d want 4", rsp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rsp_q[i].c !== ec[i] || rsp_q[i].s !== es[i] || rsp_q[i].id !== 1'b1) begin
                    failures++;
                    $display("FAIL quad_data q=%0d got %h/%h id=%b want %h/%h id=1",
                             i, rsp_q[i].c, rsp_q[i].s, rsp_q[i].id, ec[i], es[i]);
                end
            end
        end
    endtask

    task automatic test_wrap_saturation();
        logic [14:0] ks [5];
        logic [15:0] ec [5];
        logic [15:0] es [5];
        ks = '{15'd32767, 15'd8192, 15'd0, 15'd16384, 15'd0};
        ec = '{16'h3FFE, 16'h0000, 16'h1000, 16'h7FFF, 16'h8000};
        es = '{16'hD001, 16'h1000, 16'h0000, 16'h0000, 16'h0000};
        acc_q.delete(); rsp_q.delete();
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                repeat (6) @(posedge clk_fft);
                force_min = 1'b1;
            end
            @(posedge clk_fft); #1;
            req0_valid = 1'b1; req0_index = ks[i];
            @(posedge clk_fft); #1;
            req0_valid = 1'b0;
        end
        repeat (6) @(posedge clk_fft);
        force_min = 1'b0;
        @(negedge clk_fft);
        checks++;
        if (rsp_q.size() != 5) begin
            failures++;
            $display("FAIL wrap_count got %0d want 5", rsp_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rsp_q[i].c !== ec[i] || rsp_q[i].s !== es[i]) begin
                    failures++;
                    $display("FAIL wrap_sat k=%0d got %h/%h want %h/%h",
                             ks[i], rsp_q[i].c, rsp_q[i].s, ec[i], es[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        acc_q.delete(); rsp_q.delete();
        @(posedge clk_fft); #1;
        req0_valid = 1'b1; req0_index = 15'd1;
        @(posedge clk_fft); #1;
        req0_index = 15'd2;
        @(posedge clk_fft); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk_fft);
        rsp_q.delete();
        @(negedge clk_fft);
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rom_add !== 13'd0) begin
            failures++;
            $display("FAIL rstmid_ctrl got v=%b busy=%b add=%0d want 0", rsp_valid, busy, rom_add);
        end
        checks++;
        if (rsp_cos !== 16'h0 || rsp_sin !== 16'h0 || rsp_id !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_data got %h/%h id=%b want 0", rsp_cos, rsp_sin, rsp_id);
        end
        req0_valid = 1'b1; req0_index = 15'd3;
        req1_valid = 1'b1; req1_index = 15'd4;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ready got %b%b want 00", req0_ready, req1_ready);
        end
        @(posedge clk_fft); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_first got %b%b want 10", req0_ready, req1_ready);
        end
        @(posedge clk_fft); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk_fft);
        @(negedge clk_fft);
        checks++;
        if (rsp_q.size() != 1) begin
            failures++;
            $display("FAIL rstmid_drop got %0d rsp want 1", rsp_q.size());
        end else begin
            checks++;
            if (rsp_q[0].id !== 1'b0 || rsp_q[0].c !== 16'h1003 || rsp_q[0].s !== 16'h0006) begin
                failures++;
                $display("FAIL rstmid_rsp got id=%b %h/%h want id=0 1003/0006",
                         rsp_q[0].id, rsp_q[0].c, rsp_q[0].s);
            end
        end
    endtask

    task automatic test_enable();
        int t;
        @(posedge clk_fft); #1;
        enable = 1'b1;
        req0_valid = 1'b1; req0_index = 15'd3;
        req1_valid = 1'b1; req1_index = 15'd5;
        @(negedge clk_fft);
        t = cyc + 1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL en_grant got %b%b want 01", req0_ready, req1_ready);
        end
        @(posedge clk_fft); #1;
        enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_fft);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL en_off j=%0d got ready=%b%b busy=%b want 00 1",
                         j, req0_ready, req1_ready, busy);
            end
            checks++;
            if (rsp_valid !== (cyc == t + 3)) begin
                failures++;
                $display("FAIL en_rsp_time j=%0d got %b want %b", j, rsp_valid, cyc == t + 3);
            end
        end
        checks++;
        if (rsp_id !== 1'b1 || rsp_cos !== 16'h1005 || rsp_sin !== 16'h000A) begin
            failures++;
            $display("FAIL en_rsp_data got id=%b %h/%h want 1 1005/000A", rsp_id, rsp_cos, rsp_sin);
        end
        @(posedge clk_fft); #1;
        enable = 1'b1;
        @(negedge clk_fft);
        checks++;
        if (busy !== 1'b0 || req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL en_drain got busy=%b ready0=%b want 0 1", busy, req0_ready);
        end
        @(posedge clk_fft); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (6) @(posedge clk_fft);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        force_min = 1'b0;
        reset = 1'b1; enable = 1'b0;
        req0_valid = 1'b0; req0_index = '0;
        req1_valid = 1'b0; req1_index = '0;
        repeat (2) @(posedge clk_fft);
        test_reset();
        test_stream();
        test_alternate();
        test_quadrant();
        test_wrap_saturation();
        test_reset_mid();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
